// File: rtl/seq_alu.sv
// seq_alu: 32-bit operator unit behind a valid/ready handshake.
// MUL/DIVU/MODU iterate one bit per cycle; all other ops finish in one cycle.
module seq_alu (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        div_by_zero
);

    localparam logic [3:0] OP_ADD    = 4'd0;
    localparam logic [3:0] OP_SUB    = 4'd1;
    localparam logic [3:0] OP_MUL    = 4'd2;
    localparam logic [3:0] OP_DIVU   = 4'd3;
    localparam logic [3:0] OP_MODU   = 4'd4;
    localparam logic [3:0] OP_SHL    = 4'd5;
    localparam logic [3:0] OP_SHR    = 4'd6;
    localparam logic [3:0] OP_ASHR   = 4'd7;
    localparam logic [3:0] OP_AND    = 4'd8;
    localparam logic [3:0] OP_OR     = 4'd9;
    localparam logic [3:0] OP_XOR    = 4'd10;
    localparam logic [3:0] OP_XNOR   = 4'd11;
    localparam logic [3:0] OP_REDAND = 4'd12;
    localparam logic [3:0] OP_REDOR  = 4'd13;
    localparam logic [3:0] OP_REDXOR = 4'd14;
    localparam logic [3:0] OP_LTS    = 4'd15;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [4:0]  r_cnt;
    logic [31:0] r_acc;
    logic [31:0] r_wa;
    logic [31:0] r_wb;
    logic [31:0] r_result;
    logic        r_dbz;

    logic        w_accept;
    logic        w_iter_op;
    logic        w_last;
    logic [31:0] w_mul_acc;
    logic [32:0] w_rem_sh;
    logic [32:0] w_diff;
    logic        w_fit;
    logic [31:0] w_rem_nx;
    logic [31:0] w_quo_nx;
    logic [31:0] w_single;

    function automatic logic [31:0] f_single(
        input logic [3:0]  f_op,
        input logic [31:0] f_a,
        input logic [31:0] f_b
    );
        logic [31:0] v;
        v = 32'd0;
        case (f_op)
            OP_ADD:    v = f_a + f_b;
            OP_SUB:    v = f_a - f_b;
            OP_SHL:    v = f_b[5] ? 32'd0 : (f_a << f_b[4:0]);
            OP_SHR:    v = f_b[5] ? 32'd0 : (f_a >> f_b[4:0]);
            OP_ASHR:   v = f_b[5] ? {32{f_a[31]}}
                                  : $unsigned($signed(f_a) >>> f_b[4:0]);
            OP_AND:    v = f_a & f_b;
            OP_OR:     v = f_a | f_b;
            OP_XOR:    v = f_a ^ f_b;
            OP_XNOR:   v = ~(f_a ^ f_b);
            OP_REDAND: v = {31'd0, &f_a};
            OP_REDOR:  v = {31'd0, |f_a};
            OP_REDXOR: v = {31'd0, ^f_a};
            OP_LTS:    v = {31'd0, $signed(f_a) < $signed(f_b)};
            default:   v = 32'd0;
        endcase
        return v;
    endfunction

    assign in_ready    = (r_state == S_IDLE);
    assign out_valid   = (r_state == S_DONE);
    assign result      = r_result;
    assign div_by_zero = r_dbz;

    assign w_accept  = in_valid && (r_state == S_IDLE);
    assign w_iter_op = (op == OP_MUL) || (op == OP_DIVU) || (op == OP_MODU);
    assign w_last    = (r_cnt == 5'd31);
    assign w_single  = f_single(op, a, b);

    // Shift-add multiply: r_wa is the shifted multiplicand, r_wb the multiplier.
    assign w_mul_acc = r_acc + (r_wb[0] ? r_wa : 32'd0);

    // Restoring divide: r_acc is the remainder, r_wa shifts dividend out / quotient in.
    assign w_rem_sh = {r_acc, r_wa[31]};
    assign w_diff   = w_rem_sh - {1'b0, r_b};
    assign w_fit    = ~w_diff[32];
    assign w_rem_nx = w_fit ? w_diff[31:0] : w_rem_sh[31:0];
    assign w_quo_nx = {r_wa[30:0], w_fit};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_iter_op ? S_BUSY : S_DONE;
                end
            end
            S_BUSY: begin
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= 4'd0;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_cnt    <= 5'd0;
            r_acc    <= 32'd0;
            r_wa     <= 32'd0;
            r_wb     <= 32'd0;
            r_result <= 32'd0;
            r_dbz    <= 1'b0;
        end else if (w_accept) begin
            r_op  <= op;
            r_a   <= a;
            r_b   <= b;
            r_cnt <= 5'd0;
            r_acc <= 32'd0;
            r_wa  <= a;
            r_wb  <= b;
            if (!w_iter_op) begin
                r_result <= w_single;
                r_dbz    <= 1'b0;
            end
        end else if (r_state == S_BUSY) begin
            r_cnt <= r_cnt + 5'd1;
            if (r_op == OP_MUL) begin
                r_acc <= w_mul_acc;
                r_wa  <= {r_wa[30:0], 1'b0};
                r_wb  <= {1'b0, r_wb[31:1]};
            end else begin
                r_acc <= w_rem_nx;
                r_wa  <= w_quo_nx;
            end
            if (w_last) begin
                r_dbz <= (r_op != OP_MUL) && (r_b == 32'd0);
                case (r_op)
                    OP_MUL:  r_result <= w_mul_acc;
                    OP_DIVU: r_result <= (r_b == 32'd0) ? 32'hFFFF_FFFF
                                                        : w_quo_nx;
                    default: r_result <= (r_b == 32'd0) ? r_a : w_rem_nx;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed-vector bench for seq_alu: table of ops plus
// backpressure, ignored-input, pre-ready and mid-BUSY reset sequences.
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        div_by_zero;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic        dbz;
        int          lat;
    } vec_t;

    vec_t vecs[24];

    seq_alu dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op          (op),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_op(input logic [3:0] o, input logic [31:0] xa,
                          input logic [31:0] xb, input logic [31:0] exp,
                          input logic dbz, input int lat, input string nm);
        int   n;
        logic busy_bad;
        n        = 0;
        busy_bad = 1'b0;
        in_valid  = 1'b1;
        op        = o;
        a         = xa;
        b         = xb;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        while (!out_valid && n < 100) begin
            if (in_ready) busy_bad = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        chk({nm, " out_valid"}, {31'd0, out_valid}, 32'd1);
        chk({nm, " latency"}, 32'(n + 1), 32'(lat));
        chk({nm, " result"}, result, exp);
        chk({nm, " dbz"}, {31'd0, div_by_zero}, {31'd0, dbz});
        if (lat > 1) chk({nm, " in_ready busy"}, {31'd0, busy_bad}, 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({nm, " in_ready after"}, {31'd0, in_ready}, 32'd1);
        chk({nm, " out_valid after"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        vecs[0]  = '{4'd0,  32'd5,          32'd10,         32'd15,         1'b0, 1};
        vecs[1]  = '{4'd1,  32'd5,          32'd10,         32'hFFFF_FFFB,  1'b0, 1};
        vecs[2]  = '{4'd2,  32'h0001_0001,  32'h0001_0001,  32'h0002_0001,  1'b0, 33};
        vecs[3]  = '{4'd3,  32'd10,         32'd3,          32'd3,          1'b0, 33};
        vecs[4]  = '{4'd4,  32'd10,         32'd3,          32'd1,          1'b0, 33};
        vecs[5]  = '{4'd3,  32'd7,          32'd0,          32'hFFFF_FFFF,  1'b1, 33};
        vecs[6]  = '{4'd4,  32'd7,          32'd0,          32'd7,          1'b1, 33};
        vecs[7]  = '{4'd7,  32'hFFFF_FFFE,  32'd1,          32'hFFFF_FFFF,  1'b0, 1};
        vecs[8]  = '{4'd5,  32'd1,          32'd6,          32'd64,         1'b0, 1};
        vecs[9]  = '{4'd6,  32'd9,          32'd40,         32'd0,          1'b0, 1};
        vecs[10] = '{4'd15, 32'hFFFF_FFF6,  32'd10,         32'd1,          1'b0, 1};
        vecs[11] = '{4'd12, 32'hFFFF_FFFF,  32'd0,          32'd1,          1'b0, 1};
        vecs[12] = '{4'd14, 32'd9,          32'd0,          32'd0,          1'b0, 1};
        vecs[13] = '{4'd13, 32'd0,          32'd0,          32'd0,          1'b0, 1};
        vecs[14] = '{4'd7,  32'h8000_0000,  32'd32,         32'hFFFF_FFFF,  1'b0, 1};
        vecs[15] = '{4'd5,  32'd3,          32'h0000_0040,  32'd3,          1'b0, 1};
        vecs[16] = '{4'd8,  32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000,  1'b0, 1};
        vecs[17] = '{4'd9,  32'hF0F0_F0F0,  32'hFF00_FF00,  32'hFFF0_FFF0,  1'b0, 1};
        vecs[18] = '{4'd10, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'h0FF0_0FF0,  1'b0, 1};
        vecs[19] = '{4'd11, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF00F_F00F,  1'b0, 1};
        vecs[20] = '{4'd2,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          1'b0, 33};
        vecs[21] = '{4'd3,  32'hFFFF_FFFF,  32'h10,         32'h0FFF_FFFF,  1'b0, 33};
        vecs[22] = '{4'd4,  32'hFFFF_FFFF,  32'h10,         32'hF,          1'b0, 33};
        vecs[23] = '{4'd15, 32'd10,         32'hFFFF_FFF6,  32'd0,          1'b0, 1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        op        = 4'd0;
        a         = 32'd0;
        b         = 32'd0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset result", result, 32'd0);
        chk("reset dbz", {31'd0, div_by_zero}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 24; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp,
                   vecs[i].dbz, vecs[i].lat, $sformatf("vec%0d", i));
        end

        // Backpressure: result held while out_ready low; new requests ignored
        in_valid = 1'b1;
        op       = 4'd0;
        a        = 32'd1;
        b        = 32'd2;
        @(posedge clk);
        #1;
        op = 4'd1;
        a  = 32'd100;
        b  = 32'd1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp result %0d", i), result, 32'd3);
            chk($sformatf("bp out_valid %0d", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("bp in_ready %0d", i), {31'd0, in_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp in_ready after", {31'd0, in_ready}, 32'd1);

        // out_ready already high when DONE is entered
        out_ready = 1'b1;
        in_valid  = 1'b1;
        op        = 4'd10;
        a         = 32'h1234_5678;
        b         = 32'hFFFF_0000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("pre-ready out_valid", {31'd0, out_valid}, 32'd1);
        chk("pre-ready result", result, 32'hEDCB_5678);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("pre-ready idle", {31'd0, in_ready}, 32'd1);

        // Reset during BUSY aborts at once
        in_valid = 1'b1;
        op       = 4'd2;
        a        = 32'd3;
        b        = 32'd4;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        chk("busy before rst", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        #1;
        chk("rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst result", result, 32'd0);
        @(posedge clk);
        #1;
        chk("rst held out_valid", {31'd0, out_valid}, 32'd0);
        rst = 1'b0;
        run_op(4'd0, 32'd7, 32'd8, 32'd15, 1'b0, 1, "post-rst add");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
